core_lsu_mmio: RTL and testbench

- Parametrised load/store unit between the TOY core and data memory, with N_CH memory-mapped I/O channels at the top of the address space.
- Adds three things to the single-stdio LSU:
  - a registered request/response handshake;
  - variable-latency memory reads;
  - an OUT_DEPTH-entry posted-write buffer, so stores to output channels do not stall the core while a consumer is slow.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_out_fifo.sv | 53 +++++
 rtl/core_lsu_mmio.sv | 177 +++++++++++++++++
 tb/tb_core_lsu_mmio.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and the I/O address decoder for the TOY load/store unit.
// Channel k of N_CH lives at address 2^AW-1-k, so channels grow downward from the top.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MEM,
    MWAIT,
    IN,
    OUTQ,
    RESP
  } lsu_state_e;

  // Wide enough for the largest supported channel count (8).
  localparam int CH_W = 3;

  typedef struct packed {
    logic            is_io;
    logic [CH_W-1:0] ch;
  } io_dec_t;

  // Inputs are widened to 32 bits so a single function serves every AW/N_CH.
  function automatic io_dec_t io_decode(input logic [31:0] addr,
                                        input logic [31:0] aw,
                                        input logic [31:0] n_ch);
    logic [31:0] top;
    io_dec_t     d;
    top     = (32'd1 << aw) - 32'd1;
    d.is_io = (addr + n_ch) > top;
    d.ch    = CH_W'(top - addr);
    return d;
  endfunction

endpackage

// File: rtl/lsu_out_fifo.sv
// Synchronous FIFO with occupancy count; holds posted I/O stores.
// Pointers wrap naturally because DEPTH is a power of two.
module lsu_out_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/core_lsu_mmio.sv
// Load/store unit for the TOY core: memory port with variable read latency,
// polled input channels and a posted-write buffer for output channels.
module core_lsu_mmio
  import lsu_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int N_CH      = 1,
  parameter int OUT_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_val_i,
  input  logic               req_wen_i,
  input  logic [AW-1:0]      req_addr_i,
  input  logic [DW-1:0]      req_wdata_i,
  output logic               req_rdy_o,
  output logic               resp_val_o,
  output logic [DW-1:0]      resp_rdata_o,
  output logic               mem_val_o,
  output logic               mem_wen_o,
  output logic [AW-1:0]      mem_addr_o,
  output logic [DW-1:0]      mem_wdata_o,
  input  logic               mem_rdy_i,
  input  logic               mem_rvalid_i,
  input  logic [DW-1:0]      mem_rdata_i,
  input  logic [N_CH-1:0]    in_val_i,
  input  logic [N_CH*DW-1:0] in_data_i,
  output logic [N_CH-1:0]    in_rdy_o,
  output logic [N_CH-1:0]    out_val_o,
  output logic [DW-1:0]      out_data_o,
  input  logic [N_CH-1:0]    out_rdy_i,
  output logic               out_empty_o
);

  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

  // Lives here rather than in the package because its width follows DW.
  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [DW-1:0]   data;
  } out_entry_t;

  lsu_state_e      state, state_n;
  io_dec_t         dec;
  logic            r_wen;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [CH_W-1:0] r_ch;
  logic [DW-1:0]   rdata_q;

  logic [N_CH-1:0] ch_onehot;
  logic [N_CH-1:0] head_onehot;
  logic [DW-1:0]   in_sel_data;
  logic            in_hit;

  out_entry_t      head;
  out_entry_t      push_entry;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign dec        = io_decode(32'(req_addr_i), 32'(AW), 32'(N_CH));
  assign push_entry = '{ch: r_ch, data: r_wdata};

  always_comb begin
    ch_onehot   = '0;
    head_onehot = '0;
    in_sel_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (r_ch == CH_W'(k)) begin
        ch_onehot[k] = 1'b1;
        in_sel_data  = in_data_i[k*DW +: DW];
      end
      if (head.ch == CH_W'(k)) head_onehot[k] = 1'b1;
    end
  end

  assign in_hit = |(in_val_i & ch_onehot);

  // Drain side runs on its own so output order always equals store order.
  assign out_val_o   = fifo_empty ? '0 : head_onehot;
  assign out_data_o  = fifo_empty ? '0 : head.data;
  assign fifo_pop    = |(out_val_o & out_rdy_i);
  assign out_empty_o = (fifo_count == '0);

  lsu_out_fifo #(
    .DEPTH (OUT_DEPTH),
    .W     ($bits(out_entry_t))
  ) u_out_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_n     = state;
    req_rdy_o   = 1'b0;
    resp_val_o  = 1'b0;
    mem_val_o   = 1'b0;
    mem_wen_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    in_rdy_o    = '0;
    fifo_push   = 1'b0;
    case (state)
      IDLE: begin
        req_rdy_o = 1'b1;
        if (req_val_i) begin
          if (!dec.is_io)     state_n = MEM;
          else if (req_wen_i) state_n = OUTQ;
          else                state_n = IN;
        end
      end
      MEM: begin
        mem_val_o   = 1'b1;
        mem_wen_o   = r_wen;
        mem_addr_o  = r_addr;
        mem_wdata_o = r_wdata;
        if (mem_rdy_i) state_n = r_wen ? RESP : MWAIT;
      end
      MWAIT: begin
        if (mem_rvalid_i) state_n = RESP;
      end
      IN: begin
        in_rdy_o = ch_onehot;
        if (in_hit) state_n = RESP;
      end
      OUTQ: begin
        // Full blocks even if the head drains this same cycle.
        if (!fifo_full) begin
          fifo_push = 1'b1;
          state_n   = RESP;
        end
      end
      RESP: begin
        resp_val_o = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= IDLE;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ch    <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_val_i) begin
        r_wen   <= req_wen_i;
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
        r_ch    <= dec.ch;
      end
      if (state == MWAIT && mem_rvalid_i) rdata_q <= mem_rdata_i;
      if (state == IN && in_hit)          rdata_q <= in_sel_data;
      if ((state == MEM && mem_rdy_i && r_wen) || (state == OUTQ && !fifo_full))
        rdata_q <= '0;
    end
  end

  assign resp_rdata_o = rdata_q;

endmodule

// File: tb/tb_core_lsu_mmio.sv
// Scoreboard bench for core_lsu_mmio: memory, input-channel and posted-write paths.
module tb_core_lsu_mmio;

  localparam int AW = 8, DW = 16, N_CH = 2, OUT_DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_val, req_wen, req_rdy;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;
  logic            resp_val;
  logic [DW-1:0]   resp_rdata;
  logic            mem_val, mem_wen, mem_rdy, mem_rvalid;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic [N_CH-1:0] in_val, in_rdy, out_val, out_rdy;
  logic [N_CH*DW-1:0] in_data;
  logic [DW-1:0]   out_data;
  logic            out_empty;

  core_lsu_mmio #(.AW(AW), .DW(DW), .N_CH(N_CH), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_val_i(req_val), .req_wen_i(req_wen), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_rdy_o(req_rdy),
    .resp_val_o(resp_val), .resp_rdata_o(resp_rdata),
    .mem_val_o(mem_val), .mem_wen_o(mem_wen), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdy_i(mem_rdy), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata),
    .in_val_i(in_val), .in_data_i(in_data), .in_rdy_o(in_rdy),
    .out_val_o(out_val), .out_data_o(out_data), .out_rdy_i(out_rdy),
    .out_empty_o(out_empty)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0, n_err = 0;
  int resp_cnt = 0, last_resp_cyc = 0;
  int pop0 = 0, pop1 = 0;
  logic [DW-1:0]      exp_q[$];
  logic [N_CH+DW-1:0] out_q[$];
  logic [DW-1:0]      wr_mem[int];
  logic [N_CH+DW-1:0] prev_head;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input int a);
    if (wr_mem.exists(a)) return wr_mem[a];
    return {8'hC3, 8'(a)};
  endfunction

  // Memory model and channel-pop counters observe handshakes completed at the edge.
  always @(posedge clk) begin
    if (rst_n && mem_val && mem_rdy && mem_wen) wr_mem[int'(mem_addr)] = mem_wdata;
    if (rst_n && in_val[0] && in_rdy[0]) pop0++;
    if (rst_n && in_val[1] && in_rdy[1]) pop1++;
  end

  // Inputs change only at negedge+1, so out_rdy seen here is the value used at the
  // previous posedge, and prev_head is the head that edge saw.
  always @(negedge clk) begin
    if (rst_n && resp_val) begin
      resp_cnt++;
      last_resp_cyc = cyc;
      check("resp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("resp_rdata", 32'(resp_rdata), 32'(exp_q.pop_front()));
    end
    if (rst_n && (prev_head[N_CH+DW-1:DW] & out_rdy) != '0) begin
      check("out_expected", 32'(out_q.size() != 0), 32'd1);
      if (out_q.size() != 0) check("out_head", 32'(prev_head), 32'(out_q.pop_front()));
    end
    prev_head = rst_n ? {out_val, out_data} : '0;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, output int acc);
    int n;
    n = 0;
    req_val = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    while (!req_rdy && n < 100) begin step(); n++; end
    check("req_accepted", 32'(req_rdy), 32'd1);
    acc = cyc;
    step();
    req_val = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic wait_resp(input int start, output int rc);
    int n;
    n = 0;
    while (resp_cnt == start && n < 100) begin step(); n++; end
    check("resp_seen", 32'(resp_cnt - start), 32'd1);
    rc = last_resp_cyc;
  endtask

  // Called in the cycle the memory accepts a load; pulses rvalid d cycles later.
  task automatic load_rvalid(input int d, input logic [AW-1:0] addr);
    check("load_mem_val", 32'(mem_val), 32'd1);
    step();
    repeat (d - 1) step();
    mem_rvalid = 1'b1;
    mem_rdata  = mem_word(int'(addr));
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, rc, st, n;
    logic [AW-1:0] a;
    rst_n = 1'b0; req_val = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    mem_rdy = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    in_val = '0; in_data = '0; out_rdy = '0;
    repeat (3) step();

    check("rst_req_rdy", 32'(req_rdy), 32'd1);
    check("rst_resp_val", 32'(resp_val), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check("rst_mem_val", 32'(mem_val), 32'd0);
    check("rst_in_rdy", 32'(in_rdy), 32'd0);
    check("rst_out_val", 32'(out_val), 32'd0);
    check("rst_out_empty", 32'(out_empty), 32'd1);
    rst_n = 1'b1;
    step();

    // Memory store then load with a 3-cycle read delay.
    st = resp_cnt; exp_q.push_back(16'h0);
    issue(1'b1, 8'h10, 16'h1234, acc);
    check("st_mem_val", 32'(mem_val), 32'd1);
    check("st_mem_wen", 32'(mem_wen), 32'd1);
    check("st_mem_addr", 32'(mem_addr), 32'h10);
    check("st_mem_wdata", 32'(mem_wdata), 32'h1234);
    wait_resp(st, rc);
    check("st_latency", 32'(rc - acc), 32'd2);

    st = resp_cnt; exp_q.push_back(mem_word(32'h10));
    issue(1'b0, 8'h10, 16'h0, acc);
    load_rvalid(3, 8'h10);
    wait_resp(st, rc);
    check("ld_latency", 32'(rc - acc), 32'd5);

    // Memory backpressure for 4 cycles.
    mem_rdy = 1'b0;
    st = resp_cnt; exp_q.push_back(16'h0);
    issue(1'b1, 8'h20, 16'h5A5A, acc);
    for (int i = 0; i < 4; i++) begin
      check("bp_mem_val", 32'(mem_val), 32'd1);
      check("bp_mem_addr", 32'(mem_addr), 32'h20);
      check("bp_mem_wdata", 32'(mem_wdata), 32'h5A5A);
      check("bp_req_rdy", 32'(req_rdy), 32'd0);
      step();
    end
    mem_rdy = 1'b1;
    wait_resp(st, rc);
    check("bp_latency", 32'(rc - acc), 32'd6);
    repeat (3) step();
    check("bp_single_resp", 32'(resp_cnt - st), 32'd1);

    // I/O load on ch1 while only ch0 has data.
    in_data = {16'h0000, 16'h1111}; in_val = 2'b01;
    st = resp_cnt; exp_q.push_back(16'hBEEF);
    issue(1'b0, 8'hFE, 16'h0, acc);
    for (int i = 0; i < 3; i++) begin
      check("in_rdy_ch1", 32'(in_rdy), 32'b10);
      step();
    end
    in_data = {16'hBEEF, 16'h1111}; in_val = 2'b11;
    wait_resp(st, rc);
    in_val = '0;
    check("in_ch0_pops", 32'(pop0), 32'd0);
    check("in_ch1_pops", 32'(pop1), 32'd1);

    // Posted writes filling the buffer; fifth store stalls.
    out_rdy = '0;
    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 0) ? 8'hFF : 8'hFE;
      st = resp_cnt; exp_q.push_back(16'h0);
      out_q.push_back({2'(1 << (i % 2)), 16'(16'hA0 + i)});
      issue(1'b1, a, 16'(16'hA0 + i), acc);
      wait_resp(st, rc);
      check("pw_latency", 32'(rc - acc), 32'd2);
    end
    st = resp_cnt; exp_q.push_back(16'h0);
    out_q.push_back({2'b01, 16'hA4});
    issue(1'b1, 8'hFF, 16'hA4, acc);
    for (int i = 0; i < 4; i++) begin
      check("pw_stall", 32'(resp_cnt - st), 32'd0);
      check("pw_head_val", 32'(out_val), 32'b01);
      check("pw_head_data", 32'(out_data), 32'hA0);
      step();
    end
    out_rdy = 2'b11;
    wait_resp(st, rc);
    n = 0;
    while (!out_empty && n < 50) begin step(); n++; end
    step();
    check("pw_drained", 32'(out_empty), 32'd1);
    check("pw_all_seen", 32'(out_q.size()), 32'd0);
    out_rdy = '0;

    // Reset while in MWAIT with two buffered entries.
    for (int i = 0; i < 2; i++) begin
      st = resp_cnt; exp_q.push_back(16'h0);
      out_q.push_back({2'(1 << i), 16'(16'h11 * (i + 1))});
      issue(1'b1, 8'(8'hFF - i), 16'(16'h11 * (i + 1)), acc);
      wait_resp(st, rc);
    end
    check("rs_buf_nonempty", 32'(out_empty), 32'd0);
    st = resp_cnt;
    issue(1'b0, 8'h30, 16'h0, acc);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    out_q.delete();
    check("rs_out_empty", 32'(out_empty), 32'd1);
    check("rs_req_rdy", 32'(req_rdy), 32'd1);
    check("rs_out_val", 32'(out_val), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) step();
    check("rs_no_resp", 32'(resp_cnt - st), 32'd0);

    // Decode boundary: 0xFD is memory, 0xFE is channel 1.
    mem_rdy = 1'b0;
    st = resp_cnt; exp_q.push_back(mem_word(32'hFD));
    issue(1'b0, 8'hFD, 16'h0, acc);
    check("dec_fd_mem_val", 32'(mem_val), 32'd1);
    check("dec_fd_mem_addr", 32'(mem_addr), 32'hFD);
    mem_rdy = 1'b1;
    load_rvalid(1, 8'hFD);
    wait_resp(st, rc);
    check("dec_fd_latency", 32'(rc - acc), 32'd3);

    in_data = {16'h7777, 16'h0000}; in_val = 2'b10;
    st = resp_cnt; exp_q.push_back(16'h7777);
    issue(1'b0, 8'hFE, 16'h0, acc);
    check("dec_fe_no_mem", 32'(mem_val), 32'd0);
    check("dec_fe_in_rdy", 32'(in_rdy), 32'b10);
    wait_resp(st, rc);
    in_val = '0;
    repeat (3) step();
    check("end_exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
